// File: rtl/register_file_scoreboard.sv
// MIPS general-purpose register file with per-register pending-write scoreboard.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      rd_addr_a,
    output logic [DATA_WIDTH-1:0]      rd_data_a,
    output logic                       busy_a,
    input  logic [ADDR_WIDTH-1:0]      rd_addr_b,
    output logic [DATA_WIDTH-1:0]      rd_data_b,
    output logic                       busy_b,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       issue_en,
    input  logic [ADDR_WIDTH-1:0]      issue_addr,
    output logic [(2**ADDR_WIDTH)-1:0] busy_vec
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   wr_sel;
    logic [NUM_REGS-1:0]   issue_sel;

    // One-hot decode of the write-back and issue register numbers; bit 0 is
    // never selected so register 0 stays zero and never goes busy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_sel    = '0;
        issue_sel = '0;
        if (wr_en)
            wr_sel[wr_addr] = 1'b1;
        if (issue_en)
            issue_sel[issue_addr] = 1'b1;
        wr_sel[0]    = 1'b0;
        issue_sel[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data array is reset on purpose: a reset must clear every register.
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            busy_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i])
                    regs[i] <= wr_data;
                // Set wins over clear: a same-cycle issue leaves a new write outstanding.
                busy_q[i] <= issue_sel[i] | (busy_q[i] & ~wr_sel[i]);
            end
            busy_q[0] <= 1'b0;
        end
    end

    assign busy_vec = busy_q;

    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
        busy_a    = busy_q[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
        busy_b    = busy_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        // Forward same-cycle write-back; busy stays set only if a new issue re-reserves it.
        if (wr_en && (wr_addr != '0) && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
            busy_a    = issue_en && (issue_addr == wr_addr);
        end
        if (wr_en && (wr_addr != '0) && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
            busy_b    = issue_en && (issue_addr == wr_addr);
        end
`endif
    end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed self-checking bench for register_file_scoreboard; follows REGFILE_BYPASS_EN
// to select the expected same-cycle forwarding behaviour.
module tb_register_file_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic [31:0] busy_vec;

    int errors = 0;
    int checks = 0;

    register_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .busy_a     (busy_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .busy_b     (busy_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
    endtask

    task automatic write(input logic [4:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
    endtask

    task automatic issue(input logic [4:0] addr);
        issue_en   = 1'b1;
        issue_addr = addr;
    endtask

    initial begin
        reset     = 1'b1;
        rd_addr_a = '0;
        rd_addr_b = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Arbitrary activity, then a 2-cycle reset that also carries a write and an issue.
        write(5'd5, 32'hDEADBEEF); issue(5'd10); tick();
        idle(); write(5'd20, 32'h11112222); issue(5'd4); tick();
        reset = 1'b1;
        write(5'd6, 32'h77777777); issue(5'd8);
        tick();
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("reset_busy_vec", busy_vec, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            check($sformatf("reset_rd_a_r%0d", i), rd_data_a, 32'h0);
            check($sformatf("reset_rd_b_r%0d", 31 - i), rd_data_b, 32'h0);
            check($sformatf("reset_busy_a_r%0d", i), busy_a, 1'b0);
        end

        // Basic write then read on both ports.
        write(5'd5, 32'hDEADBEEF); tick(); idle();
        rd_addr_a = 5'd5; rd_addr_b = 5'd5; #1;
        check("basic_rd_a", rd_data_a, 32'hDEADBEEF);
        check("basic_rd_b", rd_data_b, 32'hDEADBEEF);
        check("basic_busy_a", busy_a, 1'b0);

        // Register 0 ignores writes and issues.
        write(5'd0, 32'h12345678); issue(5'd0); tick(); idle();
        rd_addr_a = 5'd0; rd_addr_b = 5'd0; #1;
        check("r0_rd_a", rd_data_a, 32'h0);
        check("r0_rd_b", rd_data_b, 32'h0);
        check("r0_busy_a", busy_a, 1'b0);
        check("r0_busy_vec", busy_vec, 32'h0);

        // Scoreboard set by an issue.
        issue(5'd9); tick(); idle();
        rd_addr_a = 5'd9; rd_addr_b = 5'd5; #1;
        check("issue9_busy_vec", busy_vec, 32'h00000200);
        check("issue9_busy_a", busy_a, 1'b1);
        check("issue9_busy_b", busy_b, 1'b0);

        // Write-back clears the busy bit and lands the data.
        write(5'd9, 32'hA5A5A5A5); tick(); idle(); #1;
        check("wb9_busy_vec", busy_vec, 32'h0);
        check("wb9_busy_a", busy_a, 1'b0);
        check("wb9_rd_a", rd_data_a, 32'hA5A5A5A5);

        // Same-cycle issue and write to a busy register: set wins, data updates.
        issue(5'd3); tick(); idle();
        rd_addr_a = 5'd3; #1;
        check("issue3_busy_vec", busy_vec, 32'h00000008);
        issue(5'd3); write(5'd3, 32'h00000042); tick(); idle(); #1;
        check("same3_busy_vec", busy_vec, 32'h00000008);
        check("same3_busy_a", busy_a, 1'b1);
        check("same3_rd_a", rd_data_a, 32'h00000042);

        // Write and issue to different registers both take effect.
        write(5'd3, 32'h00000055); issue(5'd12); tick(); idle();
        rd_addr_b = 5'd12; #1;
        check("diff_busy_vec", busy_vec, 32'h00001000);
        check("diff_rd_a", rd_data_a, 32'h00000055);
        check("diff_busy_b", busy_b, 1'b1);

        // Extra write-back to a register that is no longer busy.
        write(5'd12, 32'h0000ABCD); tick(); idle();
        write(5'd12, 32'h0000BCDE); tick(); idle(); #1;
        check("extra_rd_b", rd_data_b, 32'h0000BCDE);
        check("extra_busy_b", busy_b, 1'b0);
        check("extra_busy_vec", busy_vec, 32'h0);

        // Same-cycle write to a busy register being read.
        issue(5'd7); tick(); idle();
        rd_addr_a = 5'd7; rd_addr_b = 5'd9;
        write(5'd7, 32'hCAFEF00D); #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_rd_a", rd_data_a, 32'hCAFEF00D);
        check("byp_busy_a", busy_a, 1'b0);
`else
        check("byp_rd_a", rd_data_a, 32'h0);
        check("byp_busy_a", busy_a, 1'b1);
`endif
        check("byp_rd_b_unaffected", rd_data_b, 32'hA5A5A5A5);
        tick(); idle(); #1;
        check("byp_next_rd_a", rd_data_a, 32'hCAFEF00D);
        check("byp_next_busy_a", busy_a, 1'b0);

        // Same-cycle write and re-issue of the register being read.
        write(5'd7, 32'h0BADF00D); issue(5'd7); #1;
`ifdef REGFILE_BYPASS_EN
        check("bypiss_rd_a", rd_data_a, 32'h0BADF00D);
        check("bypiss_busy_a", busy_a, 1'b1);
`else
        check("bypiss_rd_a", rd_data_a, 32'hCAFEF00D);
        check("bypiss_busy_a", busy_a, 1'b0);
`endif
        tick(); idle(); #1;
        check("bypiss_next_rd_a", rd_data_a, 32'h0BADF00D);
        check("bypiss_next_busy_vec", busy_vec, 32'h00000080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
